// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory read port, decode handoff and execute redirect.
// master = fetch stage; slave = memory/decode/execute side.
interface instr_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_decode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_reg_fetch;
  logic [31:0] pc_fetch;
  logic        instr_valid;
  logic        fetch_misalign;

  modport master (
    output imem_req, imem_addr, instr_reg_fetch, pc_fetch, instr_valid, fetch_misalign,
    input  imem_rvalid, imem_rdata, stall_decode, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_reg_fetch, pc_fetch, instr_valid, fetch_misalign,
    output imem_rvalid, imem_rdata, stall_decode, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage: one outstanding word read, registered instruction to decode; a word landing
// during a decode stall parks in a hold buffer. Redirect beats stall, rvalid and HOLD.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_fetch_stage_if.master        bus
);
  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic        misalign_q;
  logic        drop;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic        out_free;
  logic        accept;

  assign out_free = !valid_q || !bus.stall_decode;
  assign accept   = (state == S_WAIT) && bus.imem_rvalid && !drop;

  assign bus.imem_req        = (state == S_REQ);
  assign bus.imem_addr       = {pc[31:2], 2'b00};
  assign bus.instr_reg_fetch = instr_q;
  assign bus.pc_fetch        = pc_q;
  assign bus.instr_valid     = valid_q;
  assign bus.fetch_misalign  = misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      drop       <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= RESET_PC;
    end else begin
      misalign_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      if (bus.redirect_valid) begin
        pc         <= {bus.redirect_pc[31:2], 2'b00};
        valid_q    <= 1'b0;
        instr_q    <= NOP_INSTR;
        hold_instr <= NOP_INSTR;
        hold_pc    <= RESET_PC;
        case (state)
          S_WAIT: begin
            // A response in this same cycle is the one to throw away, so no drop is armed.
            if (bus.imem_rvalid) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              drop  <= 1'b1;
            end
          end
          S_REQ: begin
            drop  <= 1'b1;
            state <= S_WAIT;
          end
          default: state <= S_REQ;
        endcase
      end else begin
        case (state)
          S_BOOT: state <= S_REQ;
          S_REQ:  state <= S_WAIT;
          S_WAIT: begin
            if (bus.imem_rvalid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= S_REQ;
              end else if (out_free) begin
                instr_q <= bus.imem_rdata;
                pc_q    <= pc;
                valid_q <= 1'b1;
                pc      <= pc + 32'd4;
                state   <= S_REQ;
              end else begin
                hold_instr <= bus.imem_rdata;
                hold_pc    <= pc;
                pc         <= pc + 32'd4;
                state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!bus.stall_decode) begin
              instr_q <= hold_instr;
              pc_q    <= hold_pc;
              state   <= S_REQ;
            end
          end
          default: state <= S_BOOT;
        endcase
        // Decode took the current word and nothing new replaces it: fall back to NOP.
        if (!bus.stall_decode && !accept && state != S_HOLD) begin
          valid_q <= 1'b0;
          instr_q <= NOP_INSTR;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus a randomized run, all checked by a
// transaction-level model (expected fetch address, queue of deliverable words).
module tb_instr_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk;
  logic rst;
  instr_fetch_stage_if bus ();

  instr_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int consumed = 0;

  // environment memory
  logic [31:0] mem [logic [31:0]];
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;
  int          mem_lat = 1;
  logic        rand_lat = 1'b0;

  // snapshot of DUT outputs taken mid-cycle
  logic        obs_req, obs_valid, obs_mis;
  logic [31:0] obs_addr, obs_instr, obs_pc;

  // reference model
  logic [31:0] q_pc [$];
  logic [31:0] q_ins [$];
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] out_addr = '0;
  logic        out_stale = 1'b1;
  logic        exp_mis = 1'b0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic model_step();
    if (rst) begin
      n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", obs_valid); end
      n_cmp++; if (obs_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", obs_req); end
      n_cmp++; if (obs_instr !== NOP) begin n_bad++; $display("FAIL rst_instr: got %h want %h", obs_instr, NOP); end
      q_pc.delete(); q_ins.delete();
      exp_addr = RESET_PC; out_stale = 1'b1; exp_mis = 1'b0;
    end else begin
      n_cmp++;
      if (obs_valid !== (q_pc.size() != 0)) begin
        n_bad++; $display("FAIL model_valid @%0d: got %b want %b", cyc, obs_valid, q_pc.size() != 0);
      end
      if (obs_valid === 1'b1 && q_pc.size() != 0) begin
        n_cmp++; if (obs_pc !== q_pc[0]) begin n_bad++; $display("FAIL model_pc @%0d: got %h want %h", cyc, obs_pc, q_pc[0]); end
        n_cmp++; if (obs_instr !== q_ins[0]) begin n_bad++; $display("FAIL model_instr @%0d: got %h want %h", cyc, obs_instr, q_ins[0]); end
        if (!bus.stall_decode) begin
          void'(q_pc.pop_front()); void'(q_ins.pop_front()); consumed++;
        end
      end else if (obs_valid === 1'b0) begin
        n_cmp++; if (obs_instr !== NOP) begin n_bad++; $display("FAIL model_nop @%0d: got %h want %h", cyc, obs_instr, NOP); end
      end
      n_cmp++; if (obs_mis !== exp_mis) begin n_bad++; $display("FAIL model_misalign @%0d: got %b want %b", cyc, obs_mis, exp_mis); end
      if (bus.imem_rvalid) begin
        if (!out_stale && !bus.redirect_valid) begin
          q_pc.push_back(out_addr); q_ins.push_back(memword(out_addr));
        end
        out_stale = 1'b1;
      end
      if (obs_req === 1'b1) begin
        n_cmp++; if (obs_addr !== exp_addr) begin n_bad++; $display("FAIL model_req_addr @%0d: got %h want %h", cyc, obs_addr, exp_addr); end
        n_cmp++; if (m_busy) begin n_bad++; $display("FAIL one_outstanding @%0d: got second req want none", cyc); end
        out_addr = exp_addr; exp_addr = exp_addr + 32'd4; out_stale = 1'b0;
      end
      if (bus.redirect_valid) begin
        out_stale = 1'b1; q_pc.delete(); q_ins.delete();
        exp_addr = {bus.redirect_pc[31:2], 2'b00};
      end
      exp_mis = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    obs_req = bus.imem_req; obs_addr = bus.imem_addr; obs_valid = bus.instr_valid;
    obs_instr = bus.instr_reg_fetch; obs_pc = bus.pc_fetch; obs_mis = bus.fetch_misalign;
    model_step();
    if (obs_req === 1'b1) begin
      m_busy = 1'b1; m_addr = obs_addr;
      m_cnt = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
    end
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = $urandom;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        bus.imem_rvalid = 1'b1; bus.imem_rdata = memword(m_addr); m_busy = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    bus.stall_decode = 1'b0; bus.redirect_valid = 1'b0;
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1; bus.redirect_pc = target; cycle();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (obs_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", obs_req); end
    n_cmp++; if (obs_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_addr: got %h want %h", obs_addr, RESET_PC); end
    n_cmp++; if (obs_instr !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h want %h", obs_instr, NOP); end
    n_cmp++; if (obs_pc !== RESET_PC) begin n_bad++; $display("FAIL reset_pc_fetch: got %h want %h", obs_pc, RESET_PC); end
    n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", obs_valid); end
    n_cmp++; if (obs_mis !== 1'b0) begin n_bad++; $display("FAIL reset_misalign: got %b want 0", obs_mis); end
  endtask

  task automatic test_basic();
    int req_n, val_n, req_c, val_c;
    logic [31:0] ra [2];
    logic [31:0] vp [2];
    logic [31:0] vi [2];
    mem.delete(); mem[32'h0] = 32'h0050_0093; mem[32'h4] = 32'h00A0_0113;
    rand_lat = 1'b0; mem_lat = 1;
    do_reset();
    req_n = 0; val_n = 0; req_c = 0; val_c = 0;
    for (int i = 0; i < 12 && (req_n < 2 || val_n < 2); i++) begin
      cycle();
      if (obs_req === 1'b1 && req_n < 2) begin if (req_n == 0) req_c = cyc; ra[req_n] = obs_addr; req_n++; end
      if (obs_valid === 1'b1 && val_n < 2) begin if (val_n == 0) val_c = cyc; vp[val_n] = obs_pc; vi[val_n] = obs_instr; val_n++; end
    end
    n_cmp++;
    if (req_n < 2 || val_n < 2) begin
      n_bad++; $display("FAIL basic_progress: got reqs=%0d valids=%0d want 2/2", req_n, val_n);
    end else begin
      n_cmp++; if (ra[0] !== 32'h0) begin n_bad++; $display("FAIL basic_addr0: got %h want 0", ra[0]); end
      n_cmp++; if (ra[1] !== 32'h4) begin n_bad++; $display("FAIL basic_addr1: got %h want 4", ra[1]); end
      n_cmp++; if (val_c - req_c != 2) begin n_bad++; $display("FAIL basic_latency: got %0d want 2", val_c - req_c); end
      n_cmp++; if (vi[0] !== 32'h0050_0093 || vp[0] !== 32'h0) begin n_bad++; $display("FAIL basic_first: got %h@%h want 00500093@0", vi[0], vp[0]); end
      n_cmp++; if (vi[1] !== 32'h00A0_0113 || vp[1] !== 32'h4) begin n_bad++; $display("FAIL basic_second: got %h@%h want 00a00113@4", vi[1], vp[1]); end
    end
  endtask

  task automatic test_stall();
    logic found;
    mem.delete(); mem[32'h0] = 32'h0050_0093; mem[32'h4] = 32'h4020_8033;
    rand_lat = 1'b0; mem_lat = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin cycle(); found = (obs_req === 1'b1); end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL stall_first_req: got none want req"); end
    bus.stall_decode = 1'b1;
    cycle(); cycle();
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h4) begin n_bad++; $display("FAIL stall_req4: got %b/%h want 1/4", obs_req, obs_addr); end
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_instr !== 32'h0050_0093 || obs_pc !== 32'h0 || obs_req !== 1'b0) begin
        n_bad++; $display("FAIL stall_frozen: got v=%b %h@%h req=%b want v=1 00500093@0 req=0", obs_valid, obs_instr, obs_pc, obs_req);
      end
    end
    bus.stall_decode = 1'b0;
    cycle(); cycle();
    n_cmp++; if (obs_instr !== 32'h4020_8033 || obs_pc !== 32'h4 || obs_valid !== 1'b1) begin n_bad++; $display("FAIL stall_release: got %h@%h v=%b want 40208033@4 v=1", obs_instr, obs_pc, obs_valid); end
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h8) begin n_bad++; $display("FAIL stall_next_req: got %b/%h want 1/8", obs_req, obs_addr); end
  endtask

  task automatic test_redirect_wait();
    logic found, got_req, got_val;
    rand_lat = 1'b0; mem_lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin cycle(); found = (obs_req === 1'b1 && obs_addr === 32'h8); end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rdw_find_req8: got none want req at 8"); end
    redirect(32'h100);
    got_req = 1'b0; got_val = 1'b0;
    for (int i = 0; i < 20 && !got_val; i++) begin
      cycle();
      if (i == 0) begin
        n_cmp++; if (obs_valid !== 1'b0 || obs_instr !== NOP) begin n_bad++; $display("FAIL rdw_flush: got v=%b %h want v=0 %h", obs_valid, obs_instr, NOP); end
      end
      if (obs_req === 1'b1 && !got_req) begin
        got_req = 1'b1;
        n_cmp++; if (obs_addr !== 32'h100) begin n_bad++; $display("FAIL rdw_req: got %h want 100", obs_addr); end
      end
      if (obs_valid === 1'b1) begin
        got_val = 1'b1;
        n_cmp++; if (obs_pc !== 32'h100) begin n_bad++; $display("FAIL rdw_first_pc: got %h want 100", obs_pc); end
      end
    end
    n_cmp++; if (!got_val) begin n_bad++; $display("FAIL rdw_timeout: got no valid want valid"); end
  endtask

  task automatic test_redirect_rvalid_hold();
    logic found;
    mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin cycle(); found = (obs_req === 1'b1); end
    redirect(32'h300);
    cycle();
    n_cmp++; if (obs_valid !== 1'b0 || obs_instr !== NOP) begin n_bad++; $display("FAIL rdr_flush: got v=%b %h want v=0 %h", obs_valid, obs_instr, NOP); end
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h300) begin n_bad++; $display("FAIL rdr_req: got %b/%h want 1/300", obs_req, obs_addr); end
    bus.stall_decode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin cycle(); found = (obs_valid === 1'b1); end
    cycle(); cycle(); cycle();
    n_cmp++; if (obs_req !== 1'b0 || obs_valid !== 1'b1) begin n_bad++; $display("FAIL rdh_in_hold: got req=%b v=%b want 0/1", obs_req, obs_valid); end
    redirect(32'h400);
    cycle();
    n_cmp++; if (obs_valid !== 1'b0 || obs_instr !== NOP) begin n_bad++; $display("FAIL rdh_flush: got v=%b %h want v=0 %h", obs_valid, obs_instr, NOP); end
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h400) begin n_bad++; $display("FAIL rdh_req: got %b/%h want 1/400", obs_req, obs_addr); end
    bus.stall_decode = 1'b0;
  endtask

  task automatic test_misalign_wrap();
    logic got;
    int nreq;
    logic [31:0] ra [2];
    mem_lat = 1;
    redirect(32'h203);
    got = 1'b0;
    for (int i = 0; i < 10 && (i < 2 || !got); i++) begin
      cycle();
      if (i == 0) begin n_cmp++; if (obs_mis !== 1'b1) begin n_bad++; $display("FAIL mis_pulse: got %b want 1", obs_mis); end end
      if (i == 1) begin n_cmp++; if (obs_mis !== 1'b0) begin n_bad++; $display("FAIL mis_clear: got %b want 0", obs_mis); end end
      if (obs_req === 1'b1 && !got) begin
        got = 1'b1;
        n_cmp++; if (obs_addr !== 32'h200) begin n_bad++; $display("FAIL mis_addr: got %h want 200", obs_addr); end
      end
    end
    redirect(32'hFFFF_FFFC);
    nreq = 0;
    for (int i = 0; i < 12 && nreq < 2; i++) begin
      cycle();
      if (obs_req === 1'b1) begin ra[nreq] = obs_addr; nreq++; end
    end
    n_cmp++;
    if (nreq < 2) begin
      n_bad++; $display("FAIL wrap_progress: got %0d reqs want 2", nreq);
    end else begin
      n_cmp++; if (ra[0] !== 32'hFFFF_FFFC || ra[1] !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h,%h want fffffffc,0", ra[0], ra[1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic found, got;
    logic [31:0] bad;
    bad = 32'hBADC_0DE5;
    mem[32'h500] = bad;
    mem_lat = 3;
    redirect(32'h500);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin cycle(); found = (obs_req === 1'b1 && obs_addr === 32'h500); end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rstmid_find: got none want req 500"); end
    rst = 1'b1;
    cycle();
    n_cmp++;
    if (obs_req !== 1'b0 || obs_addr !== RESET_PC || obs_valid !== 1'b0 || obs_instr !== NOP || obs_pc !== RESET_PC || obs_mis !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_values: got req=%b a=%h v=%b i=%h p=%h m=%b want reset values", obs_req, obs_addr, obs_valid, obs_instr, obs_pc, obs_mis);
    end
    cycle();
    rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      n_cmp++; if (obs_instr === bad) begin n_bad++; $display("FAIL rstmid_stale: got %h want not %h", obs_instr, bad); end
      if (obs_req === 1'b1 && !got) begin
        got = 1'b1;
        n_cmp++; if (obs_addr !== RESET_PC) begin n_bad++; $display("FAIL rstmid_req: got %h want %h", obs_addr, RESET_PC); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    int c0;
    rand_lat = 1'b1;
    mem.delete();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bus.stall_decode = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 5) begin
        t = $urandom;
        t = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0) | (t & 32'h0000_0FFF);
        bus.redirect_valid = 1'b1; bus.redirect_pc = t;
      end
      cycle();
    end
    bus.stall_decode = 1'b0;
    c0 = consumed;
    for (int i = 0; i < 60 && consumed < c0 + 4; i++) cycle();
    n_cmp++; if (consumed < c0 + 4) begin n_bad++; $display("FAIL random_drain: got %0d consumed want %0d", consumed - c0, 4); end
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.stall_decode = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid_hold();
    test_misalign_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Fetch stage of the RISC-V core. It holds the program counter and issues word reads to instruction memory, one outstanding request at a time. It registers the returned word into instr_reg_fetch, the instruction word consumed directly by the decode stage and the ALU control decoder. It supports decode-stage stall and execute-stage redirect (branch/jump), and presents a NOP to decode whenever no valid instruction is held.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
NOP_INSTR, 32'h0000_0013, word driven on instr_reg_fetch when instr_valid=0 (addi x0,x0,0).

Ports:
clk  input  1  core clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  read request strobe; memory always accepts in the cycle asserted.
imem_addr  output  32  word address of request; always {pc[31:2],2'b00}.
imem_rvalid  input  1  read data valid; ≥1 cycle after imem_req, exactly one per request.
imem_rdata  input  32  instruction word, qualified by imem_rvalid.
stall_decode  input  1  decode cannot accept; hold outputs.
redirect_valid  input  1  one-cycle pulse from execute: change PC and flush.
redirect_pc  input  32  new PC, qualified by redirect_valid.
instr_reg_fetch  output  32  registered instruction to decode/ALU control.
pc_fetch  output  32  PC of instr_reg_fetch.
instr_valid  output  1  instr_reg_fetch holds a real instruction.
fetch_misalign  output  1  one-cycle pulse: redirect_pc[1:0]!=0.

Behaviour:
- Reset (async, rst=1): state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_reg_fetch=NOP_INSTR, pc_fetch=RESET_PC, instr_valid=0, fetch_misalign=0, drop=0, hold buffer cleared. All outputs are registered except imem_req, which is decoded from the registered state.
- States: BOOT, REQ, WAIT, HOLD.
- BOOT: next cycle -> REQ.
- REQ: imem_req=1, imem_addr=pc; -> WAIT.
- WAIT: imem_req=0. On imem_rvalid:
  - drop=1: discard data, clear drop, -> REQ.
  - Else, if output free (instr_valid=0 or stall_decode=0): instr_reg_fetch<=imem_rdata, pc_fetch<=pc, instr_valid<=1, pc<=pc+4, -> REQ.
  - Else: capture data and pc into hold buffer, pc<=pc+4, -> HOLD.
- imem_rvalid outside WAIT is ignored, including a stale response after reset.
- HOLD: while stall_decode=1, hold all outputs. When stall_decode=0, the hold buffer loads the output regs (instr_valid stays 1), -> REQ.
- Output free, no new data (WAIT without rvalid, REQ, BOOT): if stall_decode=0, instr_valid<=0 and instr_reg_fetch<=NOP_INSTR after decode consumes.
- stall_decode=1 with instr_valid=1: instr_reg_fetch, pc_fetch and instr_valid are unchanged.
- Redirect has highest priority, over stall, rvalid and HOLD:
  - pc<=redirect_pc with [1:0] forced to 00.
  - instr_valid<=0, instr_reg_fetch<=NOP_INSTR; hold buffer discarded.
  - In WAIT without rvalid the same cycle: drop<=1, stay WAIT.
  - In WAIT with rvalid the same cycle: data discarded, -> REQ.
  - In REQ (request issued the same cycle): drop<=1, -> WAIT.
  - In HOLD or BOOT: -> REQ.
- fetch_misalign<=1 for exactly the cycle after a redirect with redirect_pc[1:0]!=0; otherwise 0.
- Second redirect while drop=1: pc updates again, drop stays 1; only one response is discarded.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC increments to 32'h0000_0000.
- Latency with 1-cycle memory: REQ at cycle t, rvalid at t+1, instr_valid=1 at t+2. Peak throughput is 1 instruction per 2 cycles.
- Reset mid-transaction returns to BOOT immediately. The outstanding response is ignored because the state is not WAIT.

Test Plan:
- Reset release, 1-cycle memory returning 0x00500093, 0x00A00113: imem_addr 0x0 then 0x4; instr_reg_fetch=0x00500093, pc_fetch=0x0, instr_valid=1 two cycles after first req; next pc_fetch=0x4.
- stall_decode=1 for 5 cycles while word at 0x4 (0x40208033) returns: outputs frozen on the 0x0 instruction, state HOLD, no imem_req. On release, instr_reg_fetch=0x40208033, pc_fetch=0x4, next req addr=0x8.
- Redirect to 0x100 while WAIT at 0x8 (3-cycle memory): instr_valid=0, instr_reg_fetch=0x13. The 0x8 response is discarded; next req addr=0x100; first valid pc_fetch=0x100.
- Redirect same cycle as rvalid, and redirect during HOLD with stall=1: data discarded, instr_valid=0, req to target next cycle, stall ignored.
- Redirect to 0x203: fetch_misalign pulses 1 cycle; fetch addr=0x200. Also pc=0xFFFF_FFFC increments to req addr 0x0.
- rst asserted mid-WAIT, released, stale rvalid arrives in BOOT: all outputs at reset values; stale data never appears; first req addr=RESET_PC.
